matrix_input_parser: RTL and testbench

MATRIX_INPUT_PARSER -- requirements
Module: matrix_input_parser

---
 rtl/matrix_input_parser.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_input_parser.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_parser.sv
// matrix_input_parser
// Turns a UART byte stream into matrix element writes. A frame is a row
// count, a column count, then rows*cols element bytes in row-major order.
// Every element byte produces one registered write strobe one cycle later,
// tagged with the destination slot, the frame dimensions and the element
// address. Completed frames advance a circular slot pointer; aborted frames
// leave it where it was.
//
// Optional feature: define PARSER_TIMEOUT_EN to abort a frame when no byte
// arrives for TIMEOUT_CYCLES clocks while a frame is in progress. Without
// the macro the parser waits indefinitely for the rest of a frame.
module matrix_input_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_SIZE       = 5,
  parameter int MATRIX_NUM     = 8,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  matrix_wr_en,
  output logic [2:0]            matrix_idx,
  output logic [2:0]            store_row,
  output logic [2:0]            store_col,
  output logic [4:0]            wr_addr_in,
  output logic [DATA_WIDTH-1:0] matrix_wr_data,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  parser_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_COL  = 2'd1,
    GET_DATA = 2'd2
  } state_t;

  // Header bytes are legal only in 1..MAX_SIZE; the last slot index wraps.
  localparam logic [DATA_WIDTH-1:0] MAX_DIM   = DATA_WIDTH'(MAX_SIZE);
  localparam logic [2:0]            LAST_SLOT = 3'(MATRIX_NUM - 1);

  state_t                state_q, state_d;
  logic [2:0]            row_q, row_d;
  logic [2:0]            col_q, col_d;
  logic [4:0]            total_q, total_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [2:0]            slot_q, slot_d;

  logic                  wr_en_q, wr_en_d;
  logic [2:0]            idx_q, idx_d;
  logic [2:0]            srow_q, srow_d;
  logic [2:0]            scol_q, scol_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  dim_ok;
  logic [2:0]            next_slot;

  assign dim_ok    = (rx_data != '0) && (rx_data <= MAX_DIM);
  assign next_slot = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;

`ifdef PARSER_TIMEOUT_EN
  localparam int            TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;
`endif

  // Frame parsing: header validation, element addressing and output staging
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    wr_en_d = 1'b0;
    idx_d   = '0;
    srow_d  = '0;
    scol_d  = '0;
    addr_d  = '0;
    data_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PARSER_TIMEOUT_EN
    to_d    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (dim_ok) begin
            row_d   = rx_data[2:0];
            state_d = GET_COL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      GET_COL: begin
        if (rx_valid) begin
          if (dim_ok) begin
            col_d   = rx_data[2:0];
            total_d = {2'b00, row_q} * {2'b00, rx_data[2:0]};
            cnt_d   = '0;
            state_d = GET_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          wr_en_d = 1'b1;
          idx_d   = slot_q;
          srow_d  = row_q;
          scol_d  = col_q;
          addr_d  = cnt_q;
          data_d  = rx_data;
          if (cnt_q == total_q - 5'd1) begin
            done_d  = 1'b1;
            slot_d  = next_slot;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef PARSER_TIMEOUT_EN
    // A silent line mid-frame abandons the frame without touching the slot.
    if (state_q != IDLE && !rx_valid) begin
      if (to_q == TO_LAST) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end

  // State, frame context and registered write/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      wr_en_q <= 1'b0;
      idx_q   <= '0;
      srow_q  <= '0;
      scol_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      wr_en_q <= wr_en_d;
      idx_q   <= idx_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef PARSER_TIMEOUT_EN
  // Idle-line counter, cleared by any byte and whenever no frame is open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  assign matrix_wr_en   = wr_en_q;
  assign matrix_idx     = idx_q;
  assign store_row      = srow_q;
  assign store_col      = scol_q;
  assign wr_addr_in     = addr_q;
  assign matrix_wr_data = data_q;
  assign frame_done     = done_q;
  assign frame_err      = err_q;
  assign parser_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_input_parser.sv
// tb_matrix_input_parser
// Drives byte streams into matrix_input_parser and compares every response
// against a frame-level reference model (byte position within the frame,
// dimensions and a circular slot number). Timeout behaviour is checked in
// whichever form the build selects via PARSER_TIMEOUT_EN.
module tb_matrix_input_parser;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          matrix_wr_en;
  logic [2:0]    matrix_idx;
  logic [2:0]    store_row;
  logic [2:0]    store_col;
  logic [4:0]    wr_addr_in;
  logic [DW-1:0] matrix_wr_data;
  logic          frame_done;
  logic          frame_err;
  logic          parser_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position inside the current frame (0 = expecting rows,
  // 1 = expecting cols, 2+ = element number pos-2), dims and slot number.
  int m_pos  = 0;
  int m_rows = 0;
  int m_cols = 0;
  int m_slot = 0;

  logic          e_wr, e_done, e_err, e_busy;
  logic [2:0]    e_idx, e_row, e_col;
  logic [4:0]    e_addr;
  logic [DW-1:0] e_data;

  matrix_input_parser #(
    .DATA_WIDTH    (DW),
    .MAX_SIZE      (5),
    .MATRIX_NUM    (8),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .matrix_wr_en  (matrix_wr_en),
    .matrix_idx    (matrix_idx),
    .store_row     (store_row),
    .store_col     (store_col),
    .wr_addr_in    (wr_addr_in),
    .matrix_wr_data(matrix_wr_data),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .parser_busy   (parser_busy)
  );

  always #5 clk = ~clk;

  // Observed outputs; write payload only matters when a write is expected
  function automatic logic [25:0] obs_bus();
    return {matrix_wr_en, frame_done, frame_err, parser_busy,
            e_wr ? {matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data} : 22'd0};
  endfunction

  function automatic logic [25:0] exp_bus();
    return {e_wr, e_done, e_err, e_busy,
            e_wr ? {e_idx, e_row, e_col, e_addr, e_data} : 22'd0};
  endfunction

  function automatic logic [25:0] all_outputs();
    return {matrix_wr_en, frame_done, frame_err, parser_busy,
            matrix_idx, store_row, store_col, wr_addr_in, matrix_wr_data};
  endfunction

  // Predict the parser's reaction to one input cycle
  task automatic model_step(input logic v, input logic [DW-1:0] d);
    int k;
    e_wr = 0; e_done = 0; e_err = 0;
    e_idx = 0; e_row = 0; e_col = 0; e_addr = 0; e_data = 0;
    if (v) begin
      if (m_pos == 0) begin
        if (d >= 1 && d <= 5) begin m_rows = int'(d); m_pos = 1; end
        else e_err = 1;
      end else if (m_pos == 1) begin
        if (d >= 1 && d <= 5) begin m_cols = int'(d); m_pos = 2; end
        else begin e_err = 1; m_pos = 0; end
      end else begin
        k      = m_pos - 2;
        e_wr   = 1;
        e_idx  = 3'(m_slot);
        e_row  = 3'(m_rows);
        e_col  = 3'(m_cols);
        e_addr = 5'(k);
        e_data = d;
        if (k == m_rows * m_cols - 1) begin
          e_done = 1;
          m_slot = (m_slot + 1) % 8;
          m_pos  = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
    e_busy = (m_pos != 0);
  endtask

  // Present one input cycle; on return the DUT response is visible
  task automatic send(input logic v, input logic [DW-1:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge clk);
    rx_valid = 1'b0;
    model_step(v, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_pos  = 0;
    m_slot = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h02;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (all_outputs() !== 26'd0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h want 0", i, all_outputs());
      end
    end
    rx_valid = 1'b0;
    rst = 1'b0;
    m_pos = 0; m_slot = 0;
  endtask

  task automatic test_basic_frame();
    logic [DW-1:0] bytes[$] = '{8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    foreach (bytes[i]) begin
      send(1'b1, bytes[i]);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL basic_frame byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_slot_wrap();
    int dones = 0;
    for (int f = 0; f < 9; f++) begin
      for (int b = 0; b < 3; b++) begin
        send(1'b1, (b == 2) ? 8'hAA : 8'h01);
        if (frame_done === 1'b1) dones++;
        n_cmp++;
        if (obs_bus() !== exp_bus()) begin
          n_bad++;
          $display("[TB] FAIL slot_wrap frame %0d byte %0d: got %h want %h", f, b, obs_bus(), exp_bus());
        end
      end
    end
    n_cmp++;
    if (dones != 9) begin
      n_bad++;
      $display("[TB] FAIL slot_wrap_done_count: got %0d want 9", dones);
    end
  endtask

  task automatic test_header_errors();
    logic [DW-1:0] bytes[$] = '{8'h06, 8'h00, 8'h02, 8'h07, 8'h01, 8'h01, 8'h5C};
    do_reset();
    foreach (bytes[i]) begin
      send(1'b1, bytes[i]);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL header_errors byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_full_frame();
    int writes = 0;
    logic [DW-1:0] d;
    for (int i = 0; i < 30; i++) begin
      if (i == 0 || i == 1)       d = 8'h05;
      else if (i == 27 || i == 28) d = 8'h01;
      else                         d = 8'($urandom_range(0, 255));
      send(1'b1, d);
      if (i < 27 && matrix_wr_en === 1'b1) writes++;
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL full_frame byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
    n_cmp++;
    if (writes != 25) begin
      n_bad++;
      $display("[TB] FAIL full_frame_write_count: got %0d want 25", writes);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [DW-1:0] bytes[$] = '{8'h02, 8'h02, 8'h31, 8'h32, 8'h33};
    foreach (bytes[i]) begin
      send(1'b1, bytes[i]);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_frame byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (all_outputs() !== 26'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_frame_async: got %h want 0", all_outputs());
    end
    @(negedge clk);
    n_cmp++;
    if (all_outputs() !== 26'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_frame_hold: got %h want 0", all_outputs());
    end
    rst = 1'b0;
    m_pos = 0; m_slot = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, (i == 2) ? 8'hE7 : 8'h01);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL reset_mid_frame_after byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
  endtask

  task automatic test_random();
    int n;
    logic [DW-1:0] d;
    for (int f = 0; f < 40; f++) begin
      n = 0;
      do begin
        if ($urandom_range(0, 3) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            send(1'b0, 8'($urandom));
            n_cmp++;
            if (obs_bus() !== exp_bus()) begin
              n_bad++;
              $display("[TB] FAIL random_gap frame %0d: got %h want %h", f, obs_bus(), exp_bus());
            end
          end
        end
        if (m_pos < 2) d = 8'($urandom_range(0, 6));
        else           d = 8'($urandom_range(0, 255));
        send(1'b1, d);
        n++;
        n_cmp++;
        if (obs_bus() !== exp_bus()) begin
          n_bad++;
          $display("[TB] FAIL random frame %0d byte %0d: got %h want %h", f, n, obs_bus(), exp_bus());
        end
      end while (m_pos != 0);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] bytes[$] = '{8'h02, 8'h02, 8'h01};
    int err_at = -1;
    int busy_cycles = 0;
    int errs = 0;
    foreach (bytes[i]) begin
      send(1'b1, bytes[i]);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL timeout_setup byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
    for (int c = 1; c <= 110; c++) begin
      rx_valid = 1'b0;
      @(negedge clk);
      if (frame_err === 1'b1) begin
        errs++;
        if (err_at < 0) err_at = c;
      end
      if (parser_busy === 1'b1) busy_cycles++;
    end
`ifdef PARSER_TIMEOUT_EN
    n_cmp++;
    if (errs != 1 || err_at < 99 || err_at > 101) begin
      n_bad++;
      $display("[TB] FAIL timeout_pulse: got %0d pulses at cycle %0d, want 1 pulse near cycle 100", errs, err_at);
    end
    n_cmp++;
    if (parser_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_idle: busy %b want 0", parser_busy);
    end
    m_pos = 0;
    for (int i = 0; i < 3; i++) begin
      send(1'b1, (i == 2) ? 8'h3C : 8'h01);
      n_cmp++;
      if (obs_bus() !== exp_bus()) begin
        n_bad++;
        $display("[TB] FAIL timeout_slot byte %0d: got %h want %h", i, obs_bus(), exp_bus());
      end
    end
`else
    n_cmp++;
    if (errs != 0 || busy_cycles != 110) begin
      n_bad++;
      $display("[TB] FAIL no_timeout: got %0d err pulses, busy %0d/110 cycles, want 0 and 110", errs, busy_cycles);
    end
    do_reset();
`endif
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    test_reset();
    test_basic_frame();
    test_slot_wrap();
    test_header_errors();
    test_full_frame();
    test_reset_mid_frame();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
